pos_sweep_engine: RTL and testbench
===================================

# pos_sweep_engine

Parametrised sequential truth-table engine for product-of-sums functions. It evaluates a product-of-sums function of N inputs built from M programmable OR-clauses. It sweeps all 2^N input combinations in ascending order and streams one row per accepted handshake. It reports the count of rows where F=1. It is the next-generation, register-programmable replacement for fixed-gate POS circuits plus hand-written truth-table benches, and sits beside the datapath as a self-check and characterisation unit.

## Interface
- N, 4, number of function inputs (2..8); input x[N-1] is the MSB ("A"), x[0] the LSB.
- M, 3, number of OR-clauses (1..8).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; honoured only in IDLE.
- abort  in  1  terminate sweep; honoured only in RUN.
- clause_use  in  M*N  literal-present mask; clause j = bits [j*N +: N].
- clause_neg  in  M*N  literal polarity, 1 = complemented; same layout.
- busy  out  1  high in RUN and DONE.
- row_valid  out  1  row presented.
- row_ready  in  1  consumer accepts row.
- row_x  out  N  input combination of current row.
- row_clause  out  M  per-clause OR results for row_x.
- row_f  out  1  F = AND of all row_clause bits.
- done  out  1  one-cycle pulse at sweep completion.
- ones_count  out  N+1  rows accepted with row_f=1.

## Operation
- Clause j = OR over i with clause_use[j*N+i]=1 of (x[i] XOR clause_neg[j*N+i]). A clause with no used literals evaluates 0, so F=0 for all rows.
- clause_use and clause_neg are captured into internal registers when start is honoured. Later changes have no effect until the next start.
- States:
  - IDLE: row_valid=0. start=1 → RUN, index=0, ones_count cleared.
  - RUN: row_valid=1; row_x=index; row_clause and row_f are computed from the captured configuration. On valid&ready: ones_count += row_f; if index=2^N-1 → DONE, else index+1.
  - abort in RUN → IDLE, taking priority over a simultaneous handshake. That final row is not counted, no done pulse is produced, and ones_count holds the partial value.
  - DONE: done=1 for exactly one cycle, row_valid=0 → IDLE.
- start outside IDLE is ignored. abort outside RUN is ignored.
- Index counter is N+1 bits wide, with no wrap inside a sweep. ones_count cannot overflow (max 2^N).
- ones_count holds its value after DONE until the next honoured start.

## Timing
- Reset values: state IDLE, busy=0, row_valid=0, row_x=0, row_clause=0, row_f=0, done=0, ones_count=0, captured configuration=0.
- rst_n low mid-sweep forces the reset values immediately (asynchronous), with no done pulse.
- All outputs are registered.
- start sampled at edge t → row_valid=1, row_x=0 after edge t; busy=1 from the same edge.
- Row outputs are stable while row_valid=1 and row_ready=0.
- With row_ready held high, throughput is one row per cycle:
  - the last row is accepted at edge t+2^N;
  - done is high in the cycle after edge t+2^N;
  - IDLE is reached at edge t+2^N+1.
- ones_count is final when done is high.

## Configuration
- POS_SWEEP_CHECK_EN defined:
  - Adds input exp_tt [2^N-1:0], captured at start. Bit k is the expected F for x=k.
  - Adds output row_err (1). row_err = row_f XOR expected bit for row_x. It has the same timing as row_f and is 0 at reset.
  - Adds output err_count [N:0]. It counts accepted rows with row_err=1, is cleared at start and holds like ones_count.
- POS_SWEEP_CHECK_EN undefined: the exp_tt, row_err and err_count ports and their logic are absent. All other behaviour is identical.

## Test plan
- N=4, M=3, F=(A+B')(B+D)(A+C'+D'), clause_use=12'h5CB, clause_neg=12'h043, ready=1 → row_f=1 exactly at row_x 1,9,11,12,13,14,15; ones_count=7; done high in the cycle after the 16th accepted row.
- Same program with ready toggling 1,0,0 → row outputs held during stalls; 16 rows delivered in order; ones_count=7.
- clause_use=0 → all 16 rows have row_f=0; ones_count=0.
- abort asserted with row_x=5 and ready=1 → IDLE next cycle; no done pulse; ones_count equals F=1 rows accepted among x=0..4 (=1 for the program above). rst_n pulsed low at row_x=9 → all outputs at reset values immediately.
- start pulsed during RUN, and configuration changed mid-sweep → both ignored; results unchanged (ones_count=7).
- POS_SWEEP_CHECK_EN, exp_tt=16'hFA03 with the program above → row_err=1 only at x=0; err_count=1. With exp_tt=16'hFA02 → err_count=0.

Source files
------------

// File: rtl/pos_sweep_engine.sv
// pos_sweep_engine: sweeps all 2^N rows of a product-of-sums function built from M clauses.
// Outputs registered; first row appears the cycle after start; a row is held while row_ready=0.
// Define POS_SWEEP_CHECK_EN to add exp_tt / row_err / err_count comparison against a golden table.
module pos_sweep_engine #(
  parameter int N = 4,
  parameter int M = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [M*N-1:0]    clause_use,
  input  logic [M*N-1:0]    clause_neg,
`ifdef POS_SWEEP_CHECK_EN
  input  logic [(1<<N)-1:0] exp_tt,
  output logic              row_err,
  output logic [N:0]        err_count,
`endif
  output logic              busy,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [N-1:0]      row_x,
  output logic [M-1:0]      row_clause,
  output logic              row_f,
  output logic              done,
  output logic [N:0]        ones_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N:0] LAST_IDX = (N+1)'((1 << N) - 1);

  state_t           state_q, state_d;
  logic [N:0]       idx_q, idx_d;
  logic [M*N-1:0]   use_q, use_d, neg_q, neg_d;
  logic [N:0]       ones_d;
  logic [N-1:0]     x_d;
  logic [M-1:0]     cl_d;
  logic             f_d, done_d, busy_d, valid_d;
`ifdef POS_SWEEP_CHECK_EN
  logic [(1<<N)-1:0] exp_q, exp_d;
  logic              err_d;
  logic [N:0]        errc_d;
`endif

  // An unused literal contributes 0, so an empty clause forces F=0.
  function automatic logic [M-1:0] eval_clauses(input logic [N-1:0] x,
                                                input logic [M*N-1:0] use_m,
                                                input logic [M*N-1:0] neg_m);
    logic [M-1:0] c;
    c = '0;
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        c[j] = c[j] | (use_m[j*N+i] & (x[i] ^ neg_m[j*N+i]));
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    use_d   = use_q;
    neg_d   = neg_q;
    ones_d  = ones_count;
    x_d     = row_x;
    cl_d    = row_clause;
    f_d     = row_f;
    done_d  = 1'b0;
`ifdef POS_SWEEP_CHECK_EN
    exp_d   = exp_q;
    errc_d  = err_count;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          use_d   = clause_use;
          neg_d   = clause_neg;
          ones_d  = '0;
          x_d     = '0;
          cl_d    = eval_clauses('0, clause_use, clause_neg);
          f_d     = &cl_d;
`ifdef POS_SWEEP_CHECK_EN
          exp_d   = exp_tt;
          errc_d  = '0;
`endif
        end
      end
      RUN: begin
        // abort wins over a simultaneous handshake; that row is not counted
        if (abort) begin
          state_d = IDLE;
        end else if (row_ready) begin
          ones_d = ones_count + (N+1)'(row_f);
`ifdef POS_SWEEP_CHECK_EN
          errc_d = err_count + (N+1)'(row_err);
`endif
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            x_d   = idx_d[N-1:0];
            cl_d  = eval_clauses(x_d, use_q, neg_q);
            f_d   = &cl_d;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == RUN);
`ifdef POS_SWEEP_CHECK_EN
    err_d   = f_d ^ exp_d[x_d];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      use_q      <= '0;
      neg_q      <= '0;
      busy       <= 1'b0;
      row_valid  <= 1'b0;
      row_x      <= '0;
      row_clause <= '0;
      row_f      <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
`ifdef POS_SWEEP_CHECK_EN
      exp_q      <= '0;
      row_err    <= 1'b0;
      err_count  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      use_q      <= use_d;
      neg_q      <= neg_d;
      busy       <= busy_d;
      row_valid  <= valid_d;
      row_x      <= x_d;
      row_clause <= cl_d;
      row_f      <= f_d;
      done       <= done_d;
      ones_count <= ones_d;
`ifdef POS_SWEEP_CHECK_EN
      exp_q      <= exp_d;
      row_err    <= err_d;
      err_count  <= errc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pos_sweep_engine.sv
// Bench for pos_sweep_engine (N=4, M=3): table-driven sweeps, abort/reset sequences, random programs.
module tb_pos_sweep_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] clause_use = '0;
  logic [11:0] clause_neg = '0;
  logic [15:0] exp_tt = '0;
  logic        busy, row_valid, row_f, done;
  logic        row_ready = 1'b0;
  logic [3:0]  row_x;
  logic [2:0]  row_clause;
  logic [4:0]  ones_count;
`ifdef POS_SWEEP_CHECK_EN
  logic        row_err;
  logic [4:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pos_sweep_engine #(.N(4), .M(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .clause_use(clause_use), .clause_neg(clause_neg),
`ifdef POS_SWEEP_CHECK_EN
    .exp_tt(exp_tt), .row_err(row_err), .err_count(err_count),
`endif
    .busy(busy), .row_valid(row_valid), .row_ready(row_ready),
    .row_x(row_x), .row_clause(row_clause), .row_f(row_f),
    .done(done), .ones_count(ones_count)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: a clause is satisfied when any of its present literals is true.
  function automatic logic [2:0] model_clauses(input int x, input logic [11:0] cu, input logic [11:0] cn);
    logic [2:0] r;
    logic [3:0] xv;
    xv = 4'(x);
    for (int j = 0; j < 3; j++) begin
      int sat;
      sat = 0;
      for (int i = 0; i < 4; i++)
        if (cu[j*4+i] == 1'b1 && xv[i] != cn[j*4+i]) sat++;
      r[j] = (sat > 0);
    end
    return r;
  endfunction

  function automatic logic [15:0] model_tt(input logic [11:0] cu, input logic [11:0] cn);
    logic [15:0] t;
    for (int x = 0; x < 16; x++) t[x] = (model_clauses(x, cu, cn) == 3'b111);
    return t;
  endfunction

  // mode 0: ready=1, mode 1: ready pattern 1,0,0, mode 2: random ready
  task automatic sweep(input string name, input logic [11:0] cu, input logic [11:0] cn,
                       input logic [15:0] tt, input logic [15:0] mask, input int exp_ones,
                       input int exp_errs, input int mode, input int disturb);
    int acc, cyc;
    bit seen;
    logic [11:0] junk;
    acc = 0; cyc = 0; seen = 0;
    clause_use = cu; clause_neg = cn; exp_tt = tt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 300) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (row_valid) begin
        chk({name, "_busy"}, int'(busy), 1);
        chk({name, "_row_x"}, int'(row_x), acc);
        chk({name, "_row_f"}, int'(row_f), int'(mask[acc & 15]));
        chk({name, "_row_clause"}, int'(row_clause), int'(model_clauses(acc, cu, cn)));
`ifdef POS_SWEEP_CHECK_EN
        chk({name, "_row_err"}, int'(row_err), int'(mask[acc & 15] ^ tt[acc & 15]));
`endif
      end
      case (mode)
        0: row_ready = 1'b1;
        1: row_ready = (cyc % 3 == 0);
        default: row_ready = 1'($urandom_range(0, 1));
      endcase
      if (disturb != 0 && acc == 6) begin
        start = 1'b1;
        junk = 12'($urandom);
        clause_use = ~cu;
        clause_neg = junk;
        exp_tt = ~tt;
      end else begin
        start = 1'b0;
      end
      if (row_valid && row_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    row_ready = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no done expected done within 300 cycles", name);
    end else begin
      chk({name, "_rows"}, acc, 16);
      chk({name, "_ones"}, int'(ones_count), exp_ones);
      chk({name, "_done_novalid"}, int'(row_valid), 0);
      if (mode == 0) chk({name, "_done_cycle"}, cyc, 16);
`ifdef POS_SWEEP_CHECK_EN
      chk({name, "_err_count"}, int'(err_count), exp_errs);
`endif
      @(negedge clk);
      chk({name, "_done_pulse"}, int'(done), 0);
      chk({name, "_idle_busy"}, int'(busy), 0);
      chk({name, "_ones_hold"}, int'(ones_count), exp_ones);
    end
  endtask

  typedef struct {
    logic [11:0] cu;
    logic [11:0] cn;
    logic [15:0] tt;
    logic [15:0] mask;
    int          ones;
    int          errs;
    int          mode;
    int          disturb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cyc;
    logic [11:0] rcu, rcn;
    logic [15:0] rtt, rmask;

    tbl[0] = '{12'h5CB, 12'h043, 16'hFA03, 16'hFA02, 7, 1, 0, 0};
    tbl[1] = '{12'h5CB, 12'h043, 16'hFA02, 16'hFA02, 7, 0, 1, 0};
    tbl[2] = '{12'h000, 12'h000, 16'h0000, 16'h0000, 0, 0, 0, 0};
    tbl[3] = '{12'hFFF, 12'h000, 16'hFFFE, 16'hFFFE, 15, 0, 2, 0};
    tbl[4] = '{12'h888, 12'h000, 16'hFF00, 16'hFF00, 8, 0, 0, 0};
    tbl[5] = '{12'h111, 12'h111, 16'h5555, 16'h5555, 8, 0, 0, 0};
    tbl[6] = '{12'h5CB, 12'h043, 16'hFA02, 16'hFA02, 7, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row_valid", int'(row_valid), 0);
    chk("rst_row_x", int'(row_x), 0);
    chk("rst_row_clause", int'(row_clause), 0);
    chk("rst_row_f", int'(row_f), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ones", int'(ones_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++)
      sweep($sformatf("vec%0d", k), tbl[k].cu, tbl[k].cn, tbl[k].tt, tbl[k].mask,
            tbl[k].ones, tbl[k].errs, tbl[k].mode, tbl[k].disturb);

    // abort at row 5 while ready is high
    clause_use = 12'h5CB; clause_neg = 12'h043; exp_tt = 16'hFA02;
    row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (row_x != 4'd5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach_row5", int'(row_x), 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_row_valid", int'(row_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ones", int'(ones_count), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    row_ready = 1'b0;

    // asynchronous reset mid-sweep at row 9
    row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (row_x != 4'd9 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_rst_reach_row9", int'(row_x), 9);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_row_valid", int'(row_valid), 0);
    chk("mid_rst_row_x", int'(row_x), 0);
    chk("mid_rst_row_clause", int'(row_clause), 0);
    chk("mid_rst_row_f", int'(row_f), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ones", int'(ones_count), 0);
    row_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    // random programs checked against the reference model
    for (int k = 0; k < 6; k++) begin
      rcu = 12'($urandom);
      rcn = 12'($urandom);
      rtt = 16'($urandom);
      rmask = model_tt(rcu, rcn);
      sweep($sformatf("rnd%0d", k), rcu, rcn, rtt, rmask, $countones(rmask),
            $countones(rmask ^ rtt), 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
